// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared FSM encodings, frame constants and helpers for ram_loader
package ram_loader_pkg;

    // Frame layout
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         ADDR_BYTES = 4;
    localparam int         LEN_BYTES  = 2;
    localparam int         WORD_BYTES = 4;

    // Loader FSM encoding
    typedef logic [2:0] ldr_state_t;
    localparam ldr_state_t ST_IDLE = 3'd0;
    localparam ldr_state_t ST_ADDR = 3'd1;
    localparam ldr_state_t ST_LEN  = 3'd2;
    localparam ldr_state_t ST_DATA = 3'd3;
    localparam ldr_state_t ST_CSUM = 3'd4;
    localparam ldr_state_t ST_DONE = 3'd5;

    // UART receiver FSM encoding
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    // Index of the final byte of a multi-byte field
    function automatic logic [1:0] field_last(input int nbytes);
        return 2'(nbytes - 1);
    endfunction

endpackage

// File: rtl/ram_loader_uart_rx_byte.sv
// rtl/ram_loader_uart_rx_byte.sv - 8N1 UART byte receiver with input synchronizer
module uart_rx_byte
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_valid;
    logic        r_ferr;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Bit timing: confirm start at half bit, then sample every bit centre
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        // A glitch that is already high again is not a start bit
                        r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign byte_data   = r_shift;
    assign byte_valid  = r_valid;
    assign framing_err = r_ferr;

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - UART frame loader writing words to a RAM data port; LOADER_CHECKSUM_EN adds a checksum byte
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:2] ram_addr,
    output logic [3:0]  ram_wstrb,
    output logic [31:0] ram_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef LOADER_CHECKSUM_EN
    localparam ldr_state_t ST_AFTER_DATA = ST_CSUM;
`else
    localparam ldr_state_t ST_AFTER_DATA = ST_DONE;
`endif

    logic [7:0]  w_byte_data;
    logic        w_byte_valid;
    logic        w_framing_err;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic        w_unused_addr_lsb;

    ldr_state_t  r_state;
    logic [1:0]  r_idx;
    logic [23:0] r_addr_sr;
    logic [7:0]  r_len_lo;
    logic [15:0] r_words_left;
    logic [23:0] r_word_sr;
    logic [29:0] r_word_addr;
    logic [29:0] r_ram_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (w_byte_data),
        .byte_valid  (w_byte_valid),
        .framing_err (w_framing_err)
    );

    // Fields arrive little-endian, so the incoming byte is always the top one
    assign w_len             = {w_byte_data, r_len_lo};
    assign w_word            = {w_byte_data, r_word_sr};
    assign w_unused_addr_lsb = ^r_addr_sr[1:0];

    // Frame parser and RAM write sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_addr_sr    <= '0;
            r_len_lo     <= '0;
            r_words_left <= '0;
            r_word_sr    <= '0;
            r_word_addr  <= '0;
            r_ram_addr   <= '0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_wstrb <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_valid && (w_byte_data == SYNC_BYTE)) begin
                        r_state <= ST_ADDR;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (w_byte_valid) begin
                        r_addr_sr <= {w_byte_data, r_addr_sr[23:8]};
                        r_idx     <= r_idx + 2'd1;
                        if (r_idx == field_last(ADDR_BYTES)) begin
                            // Byte offset bits are dropped; the RAM is word addressed
                            r_word_addr <= {w_byte_data, r_addr_sr[23:2]};
                            r_idx       <= '0;
                            r_state     <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    if (w_byte_valid) begin
                        if (r_idx != field_last(LEN_BYTES)) begin
                            r_len_lo <= w_byte_data;
                            r_idx    <= r_idx + 2'd1;
                        end else begin
                            r_words_left <= w_len;
                            r_idx        <= '0;
                            r_state      <= (w_len == 16'd0) ? ST_AFTER_DATA : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        r_csum    <= r_csum ^ w_byte_data;
`endif
                        r_word_sr <= {w_byte_data, r_word_sr[23:8]};
                        r_idx     <= r_idx + 2'd1;
                        if (r_idx == field_last(WORD_BYTES)) begin
                            r_idx        <= '0;
                            r_wstrb      <= 4'hF;
                            r_ram_addr   <= r_word_addr;
                            r_wdata      <= w_word;
                            r_word_addr  <= r_word_addr + 30'd1;
                            r_words_left <= r_words_left - 16'd1;
                            if (r_words_left == 16'd1) begin
                                r_state <= ST_AFTER_DATA;
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_byte_valid) begin
                        if (w_byte_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            // A bad stop bit abandons the frame wherever the parser is
            if (w_framing_err) begin
                r_err   <= 1'b1;
                r_idx   <= '0;
                r_state <= ST_IDLE;
            end
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_wstrb = r_wstrb;
    assign ram_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - randomized self-checking bench for ram_loader against a frame-level model
module tb_ram_loader;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [31:2] ram_addr;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_wdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    ram_loader #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .ram_addr  (ram_addr),
        .ram_wstrb (ram_wstrb),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    wr_t         exp_q[$];
    logic [31:0] words[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every strobe must match the next write the model predicts
    always @(negedge clk) begin
        if (!reset && ram_wstrb != 4'h0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 64'(ram_wstrb), 64'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wstrb", 64'(ram_wstrb), 64'hF);
                check_eq("waddr", 64'(ram_addr), 64'(e.a));
                check_eq("wdata", 64'(ram_wdata), 64'(e.d));
            end
        end
        if (!reset && done) done_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_low);
        rx = 1'b0;
        idle_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle_cycles(CPB);
        end
        rx = stop_low ? 1'b0 : 1'b1;
        idle_cycles(CPB);
        rx = 1'b1;
        idle_cycles(stop_low ? CPB : $urandom_range(0, CPB));
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Sends one frame built from words[]; cut >= 0 resets the DUT mid data byte 'cut'
    task automatic send_frame(input logic [31:0] addr, input int n, input bit bad_csum, input int cut);
        logic [7:0]  fb[$];
        logic [7:0]  x;
        logic [15:0] len;
        wr_t         w;
        len = 16'(n);
        x   = 8'h00;
        fb.push_back(8'hA5);
        for (int i = 0; i < 4; i++) fb.push_back(addr[8*i +: 8]);
        fb.push_back(len[7:0]);
        fb.push_back(len[15:8]);
        for (int i = 0; i < n; i++) begin
            logic [31:0] wd;
            wd = words[i];
            for (int k = 0; k < 4; k++) begin
                fb.push_back(wd[8*k +: 8]);
                x = x ^ wd[8*k +: 8];
            end
            if (cut < 0 || 4 * (i + 1) <= cut) begin
                w.a = addr[31:2] + 30'(i);
                w.d = wd;
                exp_q.push_back(w);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        fb.push_back(bad_csum ? (x ^ 8'h5A) : x);
`else
        if (bad_csum) x = ~x;
`endif
        for (int j = 0; j < fb.size(); j++) begin
            if (cut >= 0 && j == 7 + cut) begin
                rx = 1'b0;
                idle_cycles(CPB);
                for (int i = 0; i < 3; i++) begin
                    rx = fb[j][i];
                    idle_cycles(CPB);
                end
                idle_cycles(CPB / 2);
                reset = 1'b1;
                idle_cycles(3);
                rx = 1'b1;
                return;
            end
            send_byte(fb[j], 1'b0);
            if (j == 0) check_eq("busy_after_sync", 64'(busy), 64'h1);
        end
    endtask

    task automatic run_frame(input logic [31:0] addr, input int n, input bit bad_csum);
        int d0;
        bit exp_err;
        d0 = done_cnt;
`ifdef LOADER_CHECKSUM_EN
        exp_err = bad_csum;
`else
        exp_err = 1'b0;
`endif
        send_frame(addr, n, bad_csum, -1);
        idle_cycles(2 * CPB);
        check_eq("done_pulse", 64'(done_cnt - d0), 64'h1);
        check_eq("err_after_frame", 64'(err), 64'(exp_err));
        check_eq("busy_after_frame", 64'(busy), 64'h0);
        check_eq("writes_pending", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"},  64'(ram_addr),  64'h0);
        check_eq({tag, "_wstrb"}, 64'(ram_wstrb), 64'h0);
        check_eq({tag, "_wdata"}, 64'(ram_wdata), 64'h0);
        check_eq({tag, "_busy"},  64'(busy),      64'h0);
        check_eq({tag, "_done"},  64'(done),      64'h0);
        check_eq({tag, "_err"},   64'(err),       64'h0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        rx    = 1'b1;
        idle_cycles(5);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle_cycles(2 * CPB);

        // Directed frame: DEADBEEF at byte address 0x100
        words.delete();
        words.push_back(32'hDEADBEEF);
        run_frame(32'h0000_0100, 1, 1'b0);
        check_eq("hold_addr", 64'(ram_addr), 64'h40);
        check_eq("hold_data", 64'(ram_wdata), 64'hDEADBEEF);

        // Word address wraps past the top of the space
        fill_random(3);
        run_frame(32'hFFFF_FFF8, 3, 1'b0);
        check_eq("wrap_last_addr", 64'(ram_addr), 64'h0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum still writes everything; next sync clears err
        fill_random(2);
        run_frame(32'h0000_2000, 2, 1'b1);
        send_byte(8'hA5, 1'b0);
        check_eq("err_cleared_by_sync", 64'(err), 64'h0);
        for (int i = 0; i < 6; i++) send_byte(8'h00, 1'b0);
        d0 = done_cnt;
        send_byte(8'h00, 1'b0);
        idle_cycles(2 * CPB);
        check_eq("empty_frame_done", 64'(done_cnt - d0), 64'h1);
        check_eq("empty_frame_err", 64'(err), 64'h0);
`endif

        // Framing error in the second address byte
        d0 = done_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        idle_cycles(2 * CPB);
        check_eq("ferr_err", 64'(err), 64'h1);
        check_eq("ferr_busy", 64'(busy), 64'h0);
        check_eq("ferr_no_done", 64'(done_cnt - d0), 64'h0);
        check_eq("ferr_no_write", 64'(exp_q.size()), 64'h0);

        // Reset in the third byte of word 2: only word 1 lands
        fill_random(3);
        send_frame(32'h0000_0400, 3, 1'b0, 6);
        @(negedge clk);
        check_reset_outputs("midreset");
        check_eq("midreset_writes", 64'(exp_q.size()), 64'h0);
        reset = 1'b0;
        idle_cycles(2 * CPB);
        @(negedge clk);
        check_reset_outputs("postreset");

        // Garbage before sync is ignored
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        check_eq("garbage_busy", 64'(busy), 64'h0);
        fill_random(2);
        run_frame(32'h1234_5678, 2, 1'b0);

        // Random frames
        for (int f = 0; f < 5; f++) begin
            int n;
            n = $urandom_range(0, 3);
            fill_random(n);
            run_frame($urandom, n, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: clk cycles per UART bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  UART serial in (8N1, LSB first, idle high); asynchronous to clk.
REQ-005 ram_addr  output  [31:2]  word address for the RAM data port.
REQ-006 ram_wstrb  output  4  byte write strobes to the RAM data port.
REQ-007 ram_wdata  output  32  write data to the RAM data port.
REQ-008 busy  output  1  high while a frame is in progress; the core is held off the RAM data port.
REQ-009 done  output  1  one-cycle pulse when a frame completes.
REQ-010 err  output  1  sticky error flag.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Receiver SHALL detect a start bit on a synchronized high-to-low transition, re-check it low at CLKS_PER_BIT/2, then sample each data bit and the stop bit at the bit centre.
REQ-013 A stop bit sampled low SHALL discard the byte, set err, and return the FSM to IDLE.
REQ-014 Frame format: sync byte 0xA5, 4 address bytes, 2 word-count bytes (N), 4N data bytes, then the checksum byte (REQ-027); all multi-byte fields little-endian.
REQ-015 FSM states: IDLE, ADDR, LEN, DATA, CSUM, DONE.
REQ-016 IDLE SHALL ignore every byte except 0xA5; on 0xA5 the FSM goes to ADDR and err clears.
REQ-017 ADDR SHALL collect 4 bytes, then go to LEN; address bits [1:0] SHALL be ignored.
REQ-018 LEN SHALL collect 2 bytes; if N=0 it goes to CSUM (or DONE without the macro), else to DATA.
REQ-019 DATA SHALL assemble 4 bytes per word and, in the cycle after the 4th byte's stop bit is sampled, drive ram_wstrb=4'hF for exactly one cycle with ram_addr = current word address and ram_wdata = assembled word.
REQ-020 Word address SHALL increment by 1 after each write and wrap from 30'h3FFFFFFF to 0.
REQ-021 After N words are written, the FSM SHALL go to CSUM (or DONE without the macro).
REQ-022 DONE SHALL last one cycle: done=1, then IDLE.
REQ-023 busy SHALL be 1 from the cycle after 0xA5 is accepted through the DONE cycle inclusive.
REQ-024 ram_wstrb SHALL be 0 in every cycle other than a REQ-019 write cycle; ram_addr and ram_wdata SHALL hold their last values between writes.
REQ-025 An 0xA5 byte received outside IDLE SHALL be treated as data, not as a resync.

Reset
REQ-026 Asserting reset at any time, including mid-byte or mid-frame, SHALL force: FSM=IDLE; receiver idle; ram_addr=0; ram_wstrb=0; ram_wdata=0; busy=0; done=0; err=0; synchronizer flops=1. No write strobe SHALL be issued from a partial frame.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined: a CSUM state SHALL receive one byte and compare it with the XOR of all data bytes (0 if N=0); on mismatch, err=1; DONE is entered either way. Without the macro: no CSUM state, no checksum byte, and err reflects framing errors only.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration and the constants SYNC_BYTE=8'hA5 and the field byte counts.
REQ-029 The UART byte receiver SHALL be a separate sub-module, uart_rx_byte, with a one-cycle byte_valid pulse and a framing_err pulse.

Verification
REQ-030 Bench SHALL cover the following directed scenarios:
- Frame A5, addr 0x00000100, N=1, data 0xDEADBEEF, csum 0x22 -> one strobe 4'hF, ram_addr=30'h40, ram_wdata=32'hDEADBEEF; done pulse; err=0.
- N=3 starting at addr 0xFFFFFFF8 -> writes at 30'h3FFFFFFE, 30'h3FFFFFFF, then 30'h0.
- Bad checksum (macro on) -> all words written, done pulses, err=1; the next 0xA5 clears err.
- Stop bit forced low in the 2nd address byte -> err=1, FSM IDLE, busy=0, no strobe.
- reset asserted during the 3rd data byte of word 2 -> only word 1 written; all outputs at reset values.
- Garbage 0x00, 0xFF before A5 -> ignored; frame loads normally.
